gate_tt_checker: RTL and testbench
==================================

Name: gate_tt_checker

Overview:
- Sequential truth-table exerciser that sits directly upstream of a 2-input primitive gate under test (OR/AND/NOT/NAND/NOR/XOR/XNOR).
- On `start` it drives all four {a,b} combinations into the gate, waits a settle time for each, and samples the gate output.
- It compares the captured truth table against the expected table for the selected gate type and reports pass/fail plus a per-vector error mask.
- Replaces hand-written initial-block stimulus with a synthesizable self-check.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15; counter width 4 bits.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a check; sampled only in IDLE
- gate_sel  input  3  0=OR 1=AND 2=NOT 3=NAND 4=NOR 5=XOR 6=XNOR 7=reserved; latched on accepted start
- dut_a  output  1  stimulus to gate input a
- dut_b  output  1  stimulus to gate input b
- dut_y  input  1  gate output being checked
- busy  output  1  high from cycle after accepted start until DONE exits
- done  output  1  one-cycle pulse at end of check
- pass  output  1  valid from done until next accepted start
- bad_sel  output  1  set when start is accepted with gate_sel=7
- captured_tt  output  4  bit i = dut_y sampled for vector i
- err_vec  output  4  bit i = mismatch on vector i

Behaviour:
- Reset values:
  - dut_a, dut_b, busy, done, pass, bad_sel = 0.
  - captured_tt, err_vec = 4'b0000.
  - FSM = IDLE, idx = 0, settle counter = 0.
- Vector index idx is 2 bits; {dut_a, dut_b} = idx, so vector order is 00, 01, 10, 11.
- Expected tables (bit i = expected output for vector i):
  - OR 1110, AND 1000, NOT 0011 (NOT = ~a; b still swept and ignored), NAND 0111, NOR 0001, XOR 0110, XNOR 1001.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 with gate_sel 0..6: latch sel; clear captured_tt, err_vec, pass, bad_sel; idx=0; go to DRIVE.
  - start=1 with gate_sel=7: set bad_sel=1, pass=0; go to DONE; dut_a/dut_b stay 0.
- DRIVE:
  - Drives {dut_a, dut_b} = idx.
  - Stays exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE (1 cycle):
  - captured_tt[idx] <= dut_y; err_vec[idx] <= dut_y ^ expected[idx].
  - If idx==3, go to DONE; otherwise idx <= idx+1 and go to DRIVE.
  - {dut_a, dut_b} hold the same vector through SAMPLE.
- DONE (1 cycle):
  - done=1.
  - pass = (err_vec final == 0) && !bad_sel; pass is registered so it is valid in the same cycle as done.
  - Then go to IDLE, with dut_a = dut_b = 0.
- Latency: accepted start at cycle 0 → done high at cycle 4*(SETTLE_CYCLES+1)+1, which is cycle 13 for the default.
- busy is high in DRIVE, SAMPLE and DONE, and low in IDLE.
- start while not IDLE is ignored; there is no queueing.
- gate_sel changes after an accepted start have no effect.
- rst mid-check: abort immediately to reset values in the next cycle; no done pulse.
- Results (pass, captured_tt, err_vec, bad_sel) hold after DONE until the next accepted start or rst.

Optional Feature:
- Macro: GATE_TT_STOP_ON_FAIL_EN
- Defined: a mismatch in SAMPLE goes straight to DONE.
  - err_vec has exactly that one bit set.
  - captured_tt bits for untested vectors remain 0.
  - done arrives early: cycle (k+1)*(SETTLE_CYCLES+1)+1 for failing vector k.
- Undefined: all four vectors are always run, and err_vec accumulates every mismatch.

Test Plan:
- gate_sel=5 with a correct XOR model, SETTLE_CYCLES=2, start at cycle 0 → done at cycle 13; pass=1; captured_tt=0110; err_vec=0000; busy high cycles 1–13.
- gate_sel=1 (AND) with an OR model attached → captured_tt=1110, err_vec=0110, pass=0. With GATE_TT_STOP_ON_FAIL_EN defined → done at cycle 7, err_vec=0010.
- gate_sel=2 (NOT) with ~a model → captured_tt=0011, pass=1. Check dut_b still toggles on vectors 01 and 11.
- gate_sel=7 → done at cycle 1; bad_sel=1; pass=0; dut_a/dut_b stay 0 throughout.
- start re-pulsed at cycle 5 during a run, and gate_sel changed to 0 at cycle 3 → run completes unaffected at cycle 13 using the original sel.
- rst asserted at cycle 6 → cycle 7 shows all outputs at reset values; no done pulse; a new start at cycle 9 runs normally.

Source files
------------

// File: rtl/gate_tt_checker.sv
// Truth-table exerciser for a 2-input primitive gate: sweeps {a,b}, samples y, compares to the expected table.
// Optional build macro GATE_TT_STOP_ON_FAIL_EN ends the sweep at the first mismatching vector.
module gate_tt_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       bad_sel,
    output logic [3:0] captured_tt,
    output logic [3:0] err_vec
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned TT_W  = 4;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_RESERVED = SEL_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    // Bit i is the expected gate output for {a,b} = i.
    function automatic logic [TT_W-1:0] expected_tt(input logic [SEL_W-1:0] sel);
        case (sel)
            3'd0:    return 4'b1110;
            3'd1:    return 4'b1000;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            3'd4:    return 4'b0001;
            3'd5:    return 4'b0110;
            3'd6:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [TT_W-1:0]   captured_q, captured_d;
    logic [TT_W-1:0]   err_q, err_d;
    logic              pass_q, pass_d;
    logic              bad_sel_q, bad_sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dut_a_q, dut_a_d;
    logic              dut_b_q, dut_b_d;
    logic              mismatch;
    logic              last_vec;
    logic [TT_W-1:0]   exp_tt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            captured_q <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
            bad_sel_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dut_a_q    <= 1'b0;
            dut_b_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            captured_q <= captured_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
            bad_sel_q  <= bad_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dut_a_q    <= dut_a_d;
            dut_b_q    <= dut_b_d;
        end
    end

    // Next-state logic; registered outputs are derived from the next state so they align with it.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        captured_d = captured_q;
        err_d      = err_q;
        pass_d     = pass_q;
        bad_sel_d  = bad_sel_q;
        exp_tt     = expected_tt(sel_q);
        mismatch   = dut_y ^ exp_tt[idx_q];
`ifdef GATE_TT_STOP_ON_FAIL_EN
        last_vec   = (idx_q == IDX_W'(3)) || mismatch;
`else
        last_vec   = (idx_q == IDX_W'(3));
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (gate_sel == SEL_RESERVED) begin
                        bad_sel_d = 1'b1;
                        pass_d    = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        sel_d      = gate_sel;
                        captured_d = '0;
                        err_d      = '0;
                        pass_d     = 1'b0;
                        bad_sel_d  = 1'b0;
                        idx_d      = '0;
                        cnt_d      = '0;
                        state_d    = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                captured_d[idx_q] = dut_y;
                err_d[idx_q]      = mismatch;
                if (last_vec) begin
                    pass_d  = (err_d == '0) && !bad_sel_q;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        if ((state_d == ST_DRIVE) || (state_d == ST_SAMPLE)) begin
            dut_a_d = idx_d[1];
            dut_b_d = idx_d[0];
        end else begin
            dut_a_d = 1'b0;
            dut_b_d = 1'b0;
        end
    end

    assign dut_a       = dut_a_q;
    assign dut_b       = dut_b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign bad_sel     = bad_sel_q;
    assign captured_tt = captured_q;
    assign err_vec     = err_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: an attached gate model (correct or wrong) and a truth-table reference model.
module tb_gate_tt_checker;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] gate_sel;
    logic       dut_a, dut_b, dut_y;
    logic       busy, done, pass, bad_sel;
    logic [3:0] captured_tt, err_vec;

    int checks = 0;
    int errors = 0;
    int model  = 5;
    logic [3:0] exp_cap = 4'b0000;
    logic [3:0] exp_err = 4'b0000;

    always #5 clk = ~clk;

    // Behavioural gate: 0 OR,1 AND,2 NOT a,3 NAND,4 NOR,5 XOR,6 XNOR.
    function automatic logic gate_ref(input int g, input logic a, input logic b);
        case (g)
            0: return a | b;
            1: return a & b;
            2: return ~a;
            3: return ~(a & b);
            4: return ~(a | b);
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return 1'b0;
        endcase
    endfunction

    assign dut_y = gate_ref(model, dut_a, dut_b);

    gate_tt_checker #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
        .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .bad_sel(bad_sel),
        .captured_tt(captured_tt), .err_vec(err_vec)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, 4'(busy), 4'(0));
        chk({tag, " done"}, 4'(done), 4'(0));
        chk({tag, " pass"}, 4'(pass), 4'(0));
        chk({tag, " bad_sel"}, 4'(bad_sel), 4'(0));
        chk({tag, " dut_ab"}, 4'({dut_a, dut_b}), 4'(0));
        chk({tag, " captured"}, captured_tt, 4'b0000);
        chk({tag, " err_vec"}, err_vec, 4'b0000);
    endtask

    // One check from start (cycle 0) to one cycle past done; disturb wiggles gate_sel/start mid-run.
    task automatic run(input int sel, input int mdl, input bit disturb);
        logic [3:0] tt, cap, err;
        logic [1:0] vv;
        int first_fail, last_v, done_cyc, v;
        bit bad, exp_pass;
        model = mdl;
        bad = (sel == 7);
        first_fail = -1;
        for (int i = 0; i < 4; i++) begin
            vv = 2'(i);
            tt[i]  = gate_ref(sel, vv[1], vv[0]);
            cap[i] = gate_ref(mdl, vv[1], vv[0]);
            err[i] = cap[i] ^ tt[i];
            if (err[i] && first_fail < 0) first_fail = i;
        end
        last_v = 3;
`ifdef GATE_TT_STOP_ON_FAIL_EN
        if (first_fail >= 0) begin
            last_v = first_fail;
            for (int i = 0; i < 4; i++) begin
                if (i > last_v) cap[i] = 1'b0;
                err[i] = (i == first_fail);
            end
        end
`endif
        if (!bad) begin
            exp_cap = cap;
            exp_err = err;
        end
        exp_pass = !bad && (err == 4'b0000);
        done_cyc = bad ? 1 : (last_v + 1) * (S + 1) + 1;

        @(negedge clk);
        gate_sel = 3'(sel);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            if (disturb && c == 3) gate_sel = 3'd0;
            start = (disturb && c == 5 && done_cyc > 6);
            v = (!bad && c < done_cyc) ? (c - 1) / (S + 1) : 0;
            vv = 2'(v);
            chk("busy", 4'(busy), 4'(c <= done_cyc));
            chk("done", 4'(done), 4'(c == done_cyc));
            chk("dut_a", 4'(dut_a), 4'(vv[1]));
            chk("dut_b", 4'(dut_b), 4'(vv[0]));
            if (c >= done_cyc) begin
                chk("pass", 4'(pass), 4'(exp_pass));
                chk("bad_sel", 4'(bad_sel), 4'(bad));
                chk("captured_tt", captured_tt, exp_cap);
                chk("err_vec", err_vec, exp_err);
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        int s, m;
        rst = 1'b1;
        start = 1'b0;
        gate_sel = 3'd0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run(5, 5, 1'b0);   // XOR, correct
        run(1, 0, 1'b0);   // AND with an OR attached
        run(2, 2, 1'b0);   // NOT
        run(7, 5, 1'b0);   // reserved select
        run(5, 5, 1'b1);   // gate_sel change and start re-pulse mid-run
        run(6, 6, 1'b0);
        run(3, 1, 1'b0);

        // Reset in the middle of a check, then a fresh run.
        model = 5;
        @(negedge clk);
        gate_sel = 3'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 6; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_rst");
        rst = 1'b0;
        exp_cap = 4'b0000;
        exp_err = 4'b0000;
        @(negedge clk);
        chk("mid_rst no done", 4'(done), 4'(0));
        run(5, 5, 1'b0);

        for (int n = 0; n < 25; n++) begin
            s = int'($urandom_range(0, 7));
            m = ($urandom_range(0, 1) == 1 && s != 7) ? s : int'($urandom_range(0, 6));
            run(s, m, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
